// File: rtl/burst_adapter.sv
// rtl/burst_adapter.sv - cache-line to memory-beat burst adapter
//
// Splits a cache-line write into BEATS memory write beats. Assembles BEATS
// returning read beats into one line for the cache side.
//
// Parameters:
//   LINE_WIDTH - cache-line width in bits
//   BEAT_WIDTH - memory beat width in bits (BEATS = LINE_WIDTH/BEAT_WIDTH, power of two >= 2)
//   ADDR_WIDTH - address width in bits
//
// Ports:
//   clk, rst_n                   - clock, synchronous active-low reset
//   dfp_addr/read/write/wdata    - cache-side request (sampled only in IDLE)
//   dfp_rdata                    - last completed read line (held across writes)
//   dfp_resp                     - one-cycle completion strobe
//   bmem_addr/read/write/wdata   - memory-side command and write beat
//   bmem_ready                   - memory accepts the read command or the write beat
//   bmem_raddr/rdata/rvalid      - memory-side returning read beat
//
// Optional feature macro: BURST_ADAPTER_RADDR_CHECK_EN
//   When defined, a read beat is counted only if bmem_raddr matches the
//   latched line address. Non-matching beats are dropped.

module burst_adapter #(
    parameter int LINE_WIDTH = 256,
    parameter int BEAT_WIDTH = 64,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] dfp_addr,
    input  logic                  dfp_read,
    input  logic                  dfp_write,
    input  logic [LINE_WIDTH-1:0] dfp_wdata,
    output logic [LINE_WIDTH-1:0] dfp_rdata,
    output logic                  dfp_resp,
    output logic [ADDR_WIDTH-1:0] bmem_addr,
    output logic                  bmem_read,
    output logic                  bmem_write,
    output logic [BEAT_WIDTH-1:0] bmem_wdata,
    input  logic                  bmem_ready,
    input  logic [ADDR_WIDTH-1:0] bmem_raddr,
    input  logic [BEAT_WIDTH-1:0] bmem_rdata,
    input  logic                  bmem_rvalid
);

    localparam int BEATS = LINE_WIDTH / BEAT_WIDTH;
    localparam int CNT_W = $clog2(BEATS);
    localparam int OFF_W = $clog2(LINE_WIDTH / 8);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_DATA,
        WR_DATA,
        RESP
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [CNT_W-1:0]        cnt;
    logic [ADDR_WIDTH-1:0]   addr_q;
    // Holds the write line during a write; reused as the read assembly buffer
    // during a read, since every slice is overwritten before completion.
    logic [LINE_WIDTH-1:0]   line_q;
    logic [LINE_WIDTH-1:0]   line_merged;
    logic                    raddr_ok;
    logic                    rd_beat;
    logic                    wr_beat;
    logic                    last_beat;

`ifdef BURST_ADAPTER_RADDR_CHECK_EN
    assign raddr_ok = (bmem_raddr == addr_q);
`else
    logic unused_raddr;
    assign raddr_ok     = 1'b1;
    assign unused_raddr = ^bmem_raddr;
`endif

    assign rd_beat   = (state == RD_DATA) && bmem_rvalid && raddr_ok;
    assign wr_beat   = (state == WR_DATA) && bmem_ready;
    assign last_beat = (cnt == CNT_W'(BEATS - 1));

    // Current buffer with the incoming beat dropped into slot cnt. On the
    // final beat this is the complete line.
    always_comb begin
        line_merged = line_q;
        line_merged[cnt*BEAT_WIDTH +: BEAT_WIDTH] = bmem_rdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        bmem_read  = 1'b0;
        bmem_write = 1'b0;
        bmem_addr  = '0;
        bmem_wdata = '0;
        dfp_resp   = 1'b0;
        case (state)
            IDLE: begin
                if (dfp_read) begin
                    state_next = RD_REQ;
                end else if (dfp_write) begin
                    state_next = WR_DATA;
                end
            end
            RD_REQ: begin
                bmem_read = 1'b1;
                bmem_addr = addr_q;
                if (bmem_ready) begin
                    state_next = RD_DATA;
                end
            end
            RD_DATA: begin
                if (rd_beat && last_beat) begin
                    state_next = RESP;
                end
            end
            WR_DATA: begin
                bmem_write = 1'b1;
                bmem_addr  = addr_q;
                bmem_wdata = line_q[cnt*BEAT_WIDTH +: BEAT_WIDTH];
                if (wr_beat && last_beat) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                dfp_resp   = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= '0;
            addr_q    <= '0;
            line_q    <= '0;
            dfp_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dfp_read || dfp_write) begin
                        addr_q <= {dfp_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                        line_q <= dfp_wdata;
                        cnt    <= '0;
                    end
                end
                RD_DATA: begin
                    if (rd_beat) begin
                        line_q <= line_merged;
                        if (last_beat) begin
                            cnt       <= '0;
                            dfp_rdata <= line_merged;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                WR_DATA: begin
                    if (wr_beat) begin
                        cnt <= last_beat ? '0 : cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_burst_adapter.sv
// tb/tb_burst_adapter.sv - randomized self-checking bench for burst_adapter
module tb_burst_adapter;

`ifdef BURST_ADAPTER_RADDR_CHECK_EN
    localparam int LW = 512;
    localparam int BW = 128;
`else
    localparam int LW = 256;
    localparam int BW = 64;
`endif
    localparam int AW = 32;
    localparam int NB = LW / BW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] dfp_addr = '0;
    logic          dfp_read = 1'b0;
    logic          dfp_write = 1'b0;
    logic [LW-1:0] dfp_wdata = '0;
    logic [LW-1:0] dfp_rdata;
    logic          dfp_resp;
    logic [AW-1:0] bmem_addr;
    logic          bmem_read;
    logic          bmem_write;
    logic [BW-1:0] bmem_wdata;
    logic          bmem_ready = 1'b0;
    logic [AW-1:0] bmem_raddr = '0;
    logic [BW-1:0] bmem_rdata = '0;
    logic          bmem_rvalid = 1'b0;

    int            checks = 0;
    int            errors = 0;
    logic [LW-1:0] last_rdata = '0;

    always #5 clk = ~clk;

    burst_adapter #(.LINE_WIDTH(LW), .BEAT_WIDTH(BW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .dfp_addr(dfp_addr), .dfp_read(dfp_read), .dfp_write(dfp_write),
        .dfp_wdata(dfp_wdata), .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp),
        .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
        .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
        .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
    );

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [AW-1:0] align(input logic [AW-1:0] a);
        return a & ~AW'(LW / 8 - 1);
    endfunction

    function automatic logic [BW-1:0] rand_beat();
        logic [BW-1:0] v;
        for (int i = 0; i < BW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        return ($urandom & 32'h0FFF_FFFF) | 32'h1000_0000;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_resp"}, dfp_resp, 0);
        check({tag, "_bmem"}, {bmem_read, bmem_write, bmem_addr, bmem_wdata}, 0);
        check({tag, "_rdata"}, dfp_rdata, last_rdata);
    endtask

    // mode 0: ready always 1; mode 1: ready low for 3 cycles on beat 1; mode 2: random ready
    task automatic do_write(input logic [AW-1:0] addr, input logic [LW-1:0] data, input int mode);
        int cyc, k, stalls, stall_left;
        bit rdy, done;
        @(negedge clk);
        check_idle("wr_idle");
        dfp_addr = addr; dfp_wdata = data; dfp_write = 1'b1; bmem_ready = 1'b1;
        cyc = 0; k = 0; stalls = 0; done = 0;
        stall_left = (mode == 1) ? 3 : 0;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) dfp_wdata = rand_line();
            if (dfp_resp) begin
                check("wr_beats", k, NB);
                check("wr_lat", cyc, NB + 1 + stalls);
                check("wr_resp_write", bmem_write, 0);
                dfp_write = 1'b0;
                done = 1;
            end else begin
                check("wr_valid", bmem_write, 1);
                check("wr_noread", bmem_read, 0);
                check("wr_addr", bmem_addr, align(addr));
                check("wr_data", bmem_wdata, data[k*BW +: BW]);
                if (mode == 1) begin
                    rdy = !(k == 1 && stall_left > 0);
                    if (!rdy) stall_left--;
                end else if (mode == 2) begin
                    rdy = ($urandom_range(0, 3) != 0);
                end else begin
                    rdy = 1'b1;
                end
                bmem_ready = rdy;
                if (rdy) k++; else stalls++;
            end
        end
        if (!done) check("wr_timeout", 0, 1);
        @(negedge clk);
        check("wr_resp_once", dfp_resp, 0);
        check("wr_keeps_rdata", dfp_rdata, last_rdata);
    endtask

    // mode 0: clean back-to-back beats; mode 1: random gaps, ignored noise, strays;
    // mode 2: clean beats with one stray after beat 2 (address check builds only)
    task automatic do_read(input logic [AW-1:0] addr, input logic [LW-1:0] line,
                           input int mode, input bit both);
        int cyc, k, last_cyc, phase;
        bit done, rdy, stray_done;
        @(negedge clk);
        check_idle("rd_idle");
        dfp_addr = addr; dfp_read = 1'b1; dfp_write = both; dfp_wdata = rand_line();
        bmem_ready = 1'b1; bmem_rvalid = 1'b0;
        cyc = 0; k = 0; last_cyc = -1; phase = 0; done = 0; stray_done = 0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            bmem_rvalid = 1'b0;
            check("rd_nowrite", bmem_write, 0);
            if (dfp_resp) begin
                check("rd_beats", k, NB);
                check("rd_lat", cyc, last_cyc + 1);
                check("rd_data", dfp_rdata, line);
                last_rdata = line;
                dfp_read = 1'b0; dfp_write = 1'b0;
                if (mode == 1) begin
                    bmem_rvalid = 1'b1; bmem_rdata = rand_beat(); bmem_raddr = align(addr);
                end
                done = 1;
            end else if (phase == 0) begin
                check("rd_cmd", bmem_read, 1);
                check("rd_addr", bmem_addr, align(addr));
                rdy = (mode != 1) || ($urandom_range(0, 2) == 0);
                bmem_ready = rdy;
                if (mode == 1 && $urandom_range(0, 1) == 1) begin
                    bmem_rvalid = 1'b1; bmem_rdata = rand_beat(); bmem_raddr = align(addr);
                end
                if (rdy) phase = 1;
            end else begin
                check("rd_cmd_off", bmem_read, 0);
                bmem_ready = 1'($urandom_range(0, 1));
`ifdef BURST_ADAPTER_RADDR_CHECK_EN
                if ((mode == 2 && k == 2 && !stray_done) ||
                    (mode == 1 && k < NB && $urandom_range(0, 3) == 0)) begin
                    bmem_rvalid = 1'b1; bmem_rdata = rand_beat(); bmem_raddr = 32'h0000_9900;
                    stray_done = 1;
                    continue;
                end
`endif
                if (k < NB && (mode != 1 || $urandom_range(0, 2) != 0)) begin
                    bmem_rvalid = 1'b1;
                    bmem_rdata = line[k*BW +: BW];
`ifdef BURST_ADAPTER_RADDR_CHECK_EN
                    bmem_raddr = align(addr);
`else
                    bmem_raddr = $urandom;
`endif
                    k++;
                    last_cyc = cyc;
                end
            end
        end
        if (!done) check("rd_timeout", 0, 1);
        @(negedge clk);
        bmem_rvalid = 1'b0;
        check("rd_resp_once", dfp_resp, 0);
    endtask

    initial begin
        logic [LW-1:0] line;
        repeat (3) @(negedge clk);
        check("rst_rdata", dfp_rdata, 0);
        check("rst_resp", dfp_resp, 0);
        check("rst_bmem", {bmem_read, bmem_write, bmem_addr, bmem_wdata}, 0);
        rst_n = 1'b1;

        for (int k = 0; k < NB; k++) line[k*BW +: BW] = {(BW / 8){8'(8'h11 * (k + 1))}};
        do_read(32'h0000_1234, line, 0, 1'b0);
        if (LW == 256) check("rd_aligned_const", align(32'h0000_1234), 32'h0000_1220);

        do_write(32'h0000_1234, rand_line(), 0);
        do_write(rand_addr(), rand_line(), 1);
        do_read(rand_addr(), rand_line(), 0, 1'b1);
`ifdef BURST_ADAPTER_RADDR_CHECK_EN
        do_read(32'h0000_1234, rand_line(), 2, 1'b0);
`endif

        // abort a read after two beats
        @(negedge clk);
        dfp_addr = rand_addr(); dfp_read = 1'b1; bmem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bmem_rvalid = 1'b1; bmem_rdata = rand_beat(); bmem_raddr = align(dfp_addr);
        @(negedge clk);
        bmem_rdata = rand_beat();
        @(negedge clk);
        check("abort_no_resp", dfp_resp, 0);
        bmem_rvalid = 1'b0; dfp_read = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        last_rdata = '0;
        check("abort_bmem_low", {bmem_read, bmem_write}, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_quiet", {dfp_resp, bmem_read, bmem_write}, 0);
        end
        do_read(rand_addr(), rand_line(), 0, 1'b0);

        for (int t = 0; t < 30; t++) begin
            case ($urandom_range(0, 2))
                0: do_write(rand_addr(), rand_line(), 2);
                1: do_read(rand_addr(), rand_line(), 1, 1'b0);
                default: do_read(rand_addr(), rand_line(), 1, 1'b1);
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
